fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: it produces the raw instruction fields consumed by the decode register (`Dreg`). It owns the PC, issues word reads on the instruction bus with at most one request outstanding, buffers returned words against decode stalls, and applies branch/jump redirects from decode, including the MIPS delay slot.

---
 rtl/fetch_unit_pkg.sv | 43 ++++
 rtl/fetch_skid.sv | 36 +++
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, reset PC, the buffered
// fetch word and the instruction field slices used by decode.
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2,
    F_FULL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] instr_sa(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry buffer holding a fetched word while the output register is busy.
// A load in the same cycle as a pop keeps the entry valid with the new word.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic        pop,
  input  fetch_word_t load_word,
  output fetch_word_t word,
  output logic        valid
);

  fetch_word_t word_r;
  logic        valid_r;

  // Entry storage with synchronous clear, load taking priority over pop.
  always_ff @(posedge clk) begin
    if (clear) begin
      word_r  <= fetch_word_t'(64'd0);
      valid_r <= 1'b0;
    end else if (load) begin
      word_r  <= load_word;
      valid_r <= 1'b1;
    end else if (pop) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign word  = word_r;
  assign valid = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word request outstanding,
// buffers returned words against decode stalls and applies delayed redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        D_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] D_pc,
  output logic [5:0]  D_icode,
  output logic [5:0]  D_acode,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [4:0]  D_rd,
  output logic [4:0]  D_sa,
  output logic [31:0] f_pc,
  output logic [31:0] pred_pc,
  output logic        f_valid
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic [31:0]  pend_pc_r, pend_pc_nxt_s;
  logic         pend_valid_r, pend_valid_nxt_s;
  logic [31:0]  f_pc_r;
  logic         ir_valid_r, ir_valid_nxt_s;
  logic [31:0]  ir_instr_r, ir_instr_nxt_s;
  logic [31:0]  ir_pc_r, ir_pc_nxt_s;
  logic [31:0]  pred_pc_r;

  logic         consume_s, resp_s, accept_s, ir_free_s;
  logic         ir_from_skid_s, ir_from_resp_s;
  logic         skid_load_s, skid_pop_s, skid_valid_s, skid_valid_nxt_s;
  logic [31:0]  redirect_aligned_s;
  fetch_word_t  resp_word_s, skid_word_s;

  // Handshake decode and routing of returned words between ir and skid.
  always_comb begin
    consume_s          = ir_valid_r & ~D_stall;
    resp_s             = (state_r == F_WAIT) & iresp_valid;
    accept_s           = (state_r == F_REQ) & ireq_ready;
    ir_free_s          = ~ir_valid_r | consume_s;
    ir_from_skid_s     = ir_free_s & skid_valid_s;
    ir_from_resp_s     = ir_free_s & ~skid_valid_s & resp_s;
    skid_pop_s         = ir_from_skid_s;
    skid_load_s        = resp_s & ~ir_from_resp_s;
    skid_valid_nxt_s   = skid_load_s | (skid_valid_s & ~skid_pop_s);
    resp_word_s.pc     = f_pc_r;
    resp_word_s.instr  = iresp_data;
    redirect_aligned_s = redirect_pc & 32'hffff_fffc;
  end

  // Fetch FSM next state: one request outstanding, stop issuing when skid is full.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      F_IDLE: state_nxt_s = F_REQ;
      F_REQ: begin
        if (accept_s) state_nxt_s = F_WAIT;
        else          state_nxt_s = F_REQ;
      end
      F_WAIT: begin
        if (resp_s) state_nxt_s = skid_valid_nxt_s ? F_FULL : F_REQ;
        else        state_nxt_s = F_WAIT;
      end
      F_FULL: begin
        if (!skid_valid_nxt_s) state_nxt_s = F_REQ;
        else                   state_nxt_s = F_FULL;
      end
      default: state_nxt_s = F_IDLE;
    endcase
  end

  // PC and pending redirect: while a request is being offered its address is
  // frozen, so a redirect is parked and applied at acceptance; outside REQ the
  // in-flight word is the delay slot and the target can go straight into pc.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_pc_nxt_s    = pend_pc_r;
    pend_valid_nxt_s = pend_valid_r;
    if (state_r == F_REQ) begin
      if (accept_s) begin
        pc_nxt_s         = pend_valid_r ? pend_pc_r : (pc_r + 32'd4);
        pend_valid_nxt_s = 1'b0;
      end else begin
        pc_nxt_s = pc_r;
      end
      if (redirect_valid) begin
        pend_pc_nxt_s    = redirect_aligned_s;
        pend_valid_nxt_s = 1'b1;
      end else begin
        pend_pc_nxt_s = pend_pc_r;
      end
    end else begin
      if (redirect_valid) begin
        pc_nxt_s         = redirect_aligned_s;
        pend_valid_nxt_s = 1'b0;
      end else if (pend_valid_r) begin
        pc_nxt_s         = pend_pc_r;
        pend_valid_nxt_s = 1'b0;
      end else begin
        pc_nxt_s = pc_r;
      end
    end
  end

  // Output instruction register; instr is zeroed when empty so decode sees a nop.
  always_comb begin
    ir_valid_nxt_s = ir_valid_r;
    ir_instr_nxt_s = ir_instr_r;
    ir_pc_nxt_s    = ir_pc_r;
    if (ir_from_skid_s) begin
      ir_valid_nxt_s = 1'b1;
      ir_instr_nxt_s = skid_word_s.instr;
      ir_pc_nxt_s    = skid_word_s.pc;
    end else if (ir_from_resp_s) begin
      ir_valid_nxt_s = 1'b1;
      ir_instr_nxt_s = resp_word_s.instr;
      ir_pc_nxt_s    = resp_word_s.pc;
    end else if (consume_s) begin
      ir_valid_nxt_s = 1'b0;
      ir_instr_nxt_s = 32'd0;
    end else begin
      ir_valid_nxt_s = ir_valid_r;
    end
  end

  // State, PC and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= F_IDLE;
      pc_r         <= RESET_PC;
      pend_pc_r    <= 32'd0;
      pend_valid_r <= 1'b0;
      f_pc_r       <= RESET_PC;
      ir_valid_r   <= 1'b0;
      ir_instr_r   <= 32'd0;
      ir_pc_r      <= RESET_PC;
      pred_pc_r    <= RESET_PC + 32'd8;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      f_pc_r       <= accept_s ? pc_r : f_pc_r;
      ir_valid_r   <= ir_valid_nxt_s;
      ir_instr_r   <= ir_instr_nxt_s;
      ir_pc_r      <= ir_pc_nxt_s;
      pred_pc_r    <= ir_pc_nxt_s + 32'd8;
    end
  end

  fetch_skid u_skid (
    .clk       (clk),
    .clear     (reset),
    .load      (skid_load_s),
    .pop       (skid_pop_s),
    .load_word (resp_word_s),
    .word      (skid_word_s),
    .valid     (skid_valid_s)
  );

  assign ireq_valid = (state_r == F_REQ);
  assign ireq_addr  = pc_r;
  assign f_valid    = ir_valid_r;
  assign f_pc       = f_pc_r;
  assign pred_pc    = pred_pc_r;
  assign D_pc       = ir_pc_r;
  assign D_icode    = instr_opcode(ir_instr_r);
  assign D_rs       = instr_rs(ir_instr_r);
  assign D_rt       = instr_rt(ir_instr_r);
  assign D_rd       = instr_rd(ir_instr_r);
  assign D_sa       = instr_sa(ir_instr_r);
  assign D_acode    = instr_funct(ir_instr_r);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small single-outstanding memory model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        D_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] D_pc;
  logic [5:0]  D_icode, D_acode;
  logic [4:0]  D_rs, D_rt, D_rd, D_sa;
  logic [31:0] f_pc;
  logic [31:0] pred_pc;
  logic        f_valid;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mem_auto;
  logic        resp_pending;
  logic [31:0] resp_addr;
  logic [31:0] a_s;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_ready     (ireq_ready),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .D_stall        (D_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .D_pc           (D_pc),
    .D_icode        (D_icode),
    .D_acode        (D_acode),
    .D_rs           (D_rs),
    .D_rt           (D_rt),
    .D_rd           (D_rd),
    .D_sa           (D_sa),
    .f_pc           (f_pc),
    .pred_pc        (pred_pc),
    .f_valid        (f_valid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h2408_0005;
    return a ^ 32'h5a5a_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: memory accepts before the edge, answers in the following cycle.
  task automatic tick();
    logic        acc;
    logic        rst_seen;
    logic [31:0] acc_addr;
    acc      = ireq_valid && ireq_ready && !reset;
    acc_addr = ireq_addr;
    rst_seen = reset;
    @(posedge clk);
    #1;
    iresp_valid = 1'b0;
    if (rst_seen) resp_pending = 1'b0;
    if (acc) begin
      resp_pending = 1'b1;
      resp_addr    = acc_addr;
    end
    if (mem_auto && resp_pending) begin
      iresp_valid  = 1'b1;
      iresp_data   = mem_word(resp_addr);
      resp_pending = 1'b0;
    end
  endtask

  // Advance past the next accepted request and return its address.
  task automatic next_accept(input string tag, output logic [31:0] a);
    logic found;
    found = 1'b0;
    a     = 32'hxxxx_xxxx;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ireq_valid && ireq_ready) begin
        a     = ireq_addr;
        found = 1'b1;
      end
      tick();
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Advance until a request for the given address has been accepted.
  task automatic wait_accept(input string tag, input logic [31:0] target);
    logic        found;
    logic [31:0] a;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ireq_valid && ireq_ready && ireq_addr == target) found = 1'b1;
      tick();
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    a = target;
  endtask

  // Advance until a valid instruction is presented.
  task automatic wait_fvalid(input string tag);
    int n;
    n = 0;
    while (!f_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, f_valid}, 32'd1);
  endtask

  initial begin
    reset          = 1'b1;
    ireq_ready     = 1'b1;
    iresp_valid    = 1'b0;
    iresp_data     = 32'd0;
    D_stall        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mem_auto       = 1'b1;
    resp_pending   = 1'b0;
    resp_addr      = 32'd0;
    #1;
    tick();
    tick();
    check("rst_ireq_valid", {31'd0, ireq_valid}, 32'd0);
    check("rst_ireq_addr", ireq_addr, RST_PC);
    check("rst_f_valid", {31'd0, f_valid}, 32'd0);
    check("rst_fields", {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, 32'd0);
    check("rst_D_pc", D_pc, RST_PC);
    check("rst_f_pc", f_pc, RST_PC);
    check("rst_pred_pc", pred_pc, 32'hbfc0_0008);

    // First fetch with zero-wait memory; decode stalled from here on.
    reset = 1'b0;
    tick();
    check("first_req_valid", {31'd0, ireq_valid}, 32'd1);
    check("first_req_addr", ireq_addr, 32'hbfc0_0000);
    tick();
    check("wait_no_req", {31'd0, ireq_valid}, 32'd0);
    check("wait_f_pc", f_pc, 32'hbfc0_0000);
    tick();
    check("addiu_valid", {31'd0, f_valid}, 32'd1);
    check("addiu_icode", {26'd0, D_icode}, 32'h0000_0009);
    check("addiu_rt", {27'd0, D_rt}, 32'd8);
    check("addiu_imm", {16'd0, D_rd, D_sa, D_acode}, 32'h0000_0005);
    check("addiu_pred_pc", pred_pc, 32'hbfc0_0008);
    check("addiu_D_pc", D_pc, 32'hbfc0_0000);

    // Stall: second word lands in skid, fetch stops issuing.
    tick();
    tick();
    check("full_no_req", {31'd0, ireq_valid}, 32'd0);
    check("full_ir_kept", D_pc, 32'hbfc0_0000);
    tick();
    tick();
    check("full_no_req2", {31'd0, ireq_valid}, 32'd0);
    check("full_ir_kept2", D_pc, 32'hbfc0_0000);
    D_stall = 1'b0;
    tick();
    check("skid_deliver_valid", {31'd0, f_valid}, 32'd1);
    check("skid_deliver_pc", D_pc, 32'hbfc0_0004);
    check("skid_deliver_instr", {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, mem_word(32'hbfc0_0004));
    check("refetch_addr", ireq_addr, 32'hbfc0_0008);
    tick();
    check("drained_f_valid", {31'd0, f_valid}, 32'd0);
    check("bubble_fields", {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, 32'd0);
    check("bubble_D_pc_hold", D_pc, 32'hbfc0_0004);

    // Branch at bfc00010, redirect while delay slot bfc00014 is in flight.
    wait_accept("accept_14", 32'hbfc0_0014);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0103;
    tick();
    redirect_valid = 1'b0;
    check("delay_slot_valid", {31'd0, f_valid}, 32'd1);
    check("delay_slot_pc", D_pc, 32'hbfc0_0014);
    check("target_req_valid", {31'd0, ireq_valid}, 32'd1);
    check("target_req_addr", ireq_addr, 32'hbfc0_0100);

    // Memory not ready for 3 cycles: address frozen, bubbles presented.
    ireq_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("nrdy_addr", ireq_addr, 32'hbfc0_0100);
      check("nrdy_valid", {31'd0, ireq_valid}, 32'd1);
      check("nrdy_f_valid", {31'd0, f_valid}, 32'd0);
      check("nrdy_fields", {D_icode, D_rs, D_rt, D_rd, D_sa, D_acode}, 32'd0);
      tick();
    end
    ireq_ready = 1'b1;
    next_accept("acc_target", a_s);
    check("acc_target_addr", a_s, 32'hbfc0_0100);
    wait_fvalid("target_valid");
    check("target_D_pc", D_pc, 32'hbfc0_0100);

    // Address wrap past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    tick();
    redirect_valid = 1'b0;
    wait_accept("accept_top", 32'hffff_fffc);
    wait_fvalid("top_valid");
    check("top_D_pc", D_pc, 32'hffff_fffc);
    check("top_pred_pc", pred_pc, 32'h0000_0004);
    next_accept("acc_wrap", a_s);
    check("wrap_addr", a_s, 32'h0000_0000);

    // Reset during WAIT; stale response one cycle later must be dropped.
    mem_auto = 1'b0;
    next_accept("acc_pre_rst", a_s);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'hdead_beef;
    tick();
    check("stale_f_valid", {31'd0, f_valid}, 32'd0);
    mem_auto = 1'b1;
    wait_fvalid("post_rst_valid");
    check("post_rst_D_pc", D_pc, RST_PC);
    check("post_rst_icode", {26'd0, D_icode}, 32'h0000_0009);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
